// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing HI/LO words.
// Shift-add multiply and restoring divide, one iteration per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] a_raw;
    logic [1:0]       op_r;
    logic             neg_a;
    logic             neg_b;

    logic             in_signed;
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             is_signed;

    always_comb begin
        in_signed = ~Op[0];
        in_neg_a  = in_signed & A[WIDTH-1];
        in_neg_b  = in_signed & B[WIDTH-1];
        in_mag_a  = in_neg_a ? -A : A;
        in_mag_b  = in_neg_b ? -B : B;
    end

    // Multiply step: conditional add into hi, then shift {hi,lo} right.
    // Divide step: shift {rem,quo} left, subtract divisor when it fits.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        rem_s   = {hi, lo[WIDTH-1]};
        diff    = rem_s[WIDTH-1:0] - mag_b;
        ge      = rem_s >= {1'b0, mag_b};
    end

    always_comb begin
        is_signed = ~op_r[0];
        prod = {hi, lo};
        quo  = lo;
        rem  = hi;
        if (is_signed && (neg_a ^ neg_b)) begin
            prod = -{hi, lo};
            quo  = -lo;
        end
        if (is_signed && neg_a) begin
            rem = -hi;
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == FINISH);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            mag_a <= '0;
            mag_b <= '0;
            a_raw <= '0;
            op_r  <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            HiOut <= '0;
            LoOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= RUN;
                        count <= '0;
                        op_r  <= Op;
                        a_raw <= A;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        mag_a <= in_mag_a;
                        mag_b <= in_mag_b;
                        hi    <= '0;
                        lo    <= Op[1] ? in_mag_a : in_mag_b;
                    end
                end
                RUN: begin
                    if (count == LAST) begin
                        state <= FINISH;
                        if (!op_r[1]) begin
                            HiOut <= prod[2*WIDTH-1:WIDTH];
                            LoOut <= prod[WIDTH-1:0];
                        end else if (mag_b == '0) begin
                            HiOut <= a_raw;
                            LoOut <= '1;
                        end else begin
                            HiOut <= rem;
                            LoOut <= quo;
                        end
                    end else begin
                        count <= count + 1'b1;
                        if (!op_r[1]) begin
                            {hi, lo} <= {add_sum, lo[WIDTH-1:1]};
                        end else begin
                            hi <= ge ? diff : rem_s[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], ge};
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vectors and corner-case sequences for mult_div_unit.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .A(A), .B(B), .Busy(Busy), .Done(Done),
        .HiOut(HiOut), .LoOut(LoOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge with the unit idle.
    task automatic accept(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op = ~op;
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (Done) break;
        end
    endtask

    task automatic watch_quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{"mult_m3x7",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{"mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{"div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{"divu_100_7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{"divu_by0",   2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[6]  = '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7]  = '{"multu_zero", 2'b01, 32'd0,         32'h0001_2345, 32'd0,         32'd0};
        vecs[8]  = '{"div_7_m2",   2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{"div_m7_by0", 2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[10] = '{"multu_sh",   2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[11] = '{"div_m8_m3",  2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_hi", HiOut, 32'd0);
        check("rst_lo", LoOut, 32'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        foreach (vecs[i]) begin
            accept(vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, {31'd0, Busy}, 32'd1);
            wait_done(cyc);
            check({vecs[i].name, "_lat"}, cyc, 33);
            check({vecs[i].name, "_hi"}, HiOut, vecs[i].hi);
            check({vecs[i].name, "_lo"}, LoOut, vecs[i].lo);
            check({vecs[i].name, "_nbusy"}, {31'd0, Busy}, 32'd0);
            @(posedge Clk);
            #1;
            check({vecs[i].name, "_pulse"}, {31'd0, Done}, 32'd0);
            check({vecs[i].name, "_hold"}, LoOut, vecs[i].lo);
        end

        // Start during RUN and during Done must both be dropped.
        accept(2'b11, 32'd9, 32'd2);
        repeat (9) @(posedge Clk);
        #1;
        Start = 1'b1;
        Op = 2'b01;
        A = 32'd5;
        B = 32'd5;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(cyc);
        check("busy_start_lat", cyc + 10, 33);
        check("busy_start_hi", HiOut, 32'd1);
        check("busy_start_lo", LoOut, 32'd4);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check("done_start_busy", {31'd0, Busy}, 32'd0);
        watch_quiet("no_queue", 40);

        // Reset in the middle of a multiply.
        accept(2'b01, 32'hFFFF_FFFF, 32'd3);
        repeat (14) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_hi", HiOut, 32'd0);
        check("abort_lo", LoOut, 32'd0);
        watch_quiet("abort_quiet", 40);

        // Reset beats Start on the same edge.
        Reset = 1'b1;
        Start = 1'b1;
        Op = 2'b01;
        A = 32'd3;
        B = 32'd3;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Start = 1'b0;
        check("rst_vs_start", {31'd0, Busy}, 32'd0);
        watch_quiet("rst_vs_start_quiet", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
